// File: rtl/sram_byte_responder_pkg.sv
// sram_byte_responder_pkg: shared FSM state encodings, byte-lane encoding and wait-state limit
package sram_byte_responder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;
  localparam int WAIT_MAX = 15;
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return lane == LANE_HI ? word[15:8] : word[7:0];
  endfunction
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable 4-bit down-counter with terminal-count flag, times the SRAM strobe
module sram_wait_counter (
  input logic clock,
  input logic reset,
  input logic load,
  input logic en,
  input logic [3:0] value,
  output logic tc
);
  logic [3:0] count;
  always_ff @(posedge clock)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (en && count != 4'd0) count <= count - 4'd1;
  assign tc = count == 4'd0;
endmodule

// File: rtl/sram_byte_responder.sv
// sram_byte_responder: CPU byte bus to 512Kx16 async SRAM responder; SRAM_PREFETCH_EN adds a one-word read buffer
module sram_byte_responder
  import sram_byte_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input logic clock,
  input logic reset,
  input logic [19:0] address,
  input logic [7:0] o_data,
  input logic we,
  input logic req,
  output logic [7:0] i_data,
  output logic ready,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input logic [15:0] sram_dq_i,
  output logic sram_dq_oe,
  output logic sram_ce_n,
  output logic sram_oe_n,
  output logic sram_we_n,
  output logic sram_ub_n,
  output logic sram_lb_n
);
  localparam logic [3:0] WS = WAIT_STATES > WAIT_MAX ? 4'(WAIT_MAX) : 4'(WAIT_STATES);
  logic [1:0] state;
  logic we_q, lane_q, tc, start, hit, done;
  logic [7:0] hit_byte;
`ifdef SRAM_PREFETCH_EN
  logic pf_valid;
  logic [18:0] pf_tag;
  logic [15:0] pf_word;
  logic pf_match;
  assign pf_match = pf_valid && pf_tag == address[19:1];
  assign hit = state == ST_IDLE && req && !we && pf_match;
  assign hit_byte = lane_byte(pf_word, address[0]);
  // Writes are write-through: the buffered byte is patched and the SRAM still gets the write.
  always_ff @(posedge clock)
    if (reset) begin
      pf_valid <= 1'b0;
      pf_tag <= '0;
      pf_word <= '0;
    end else if (done && !we_q) begin
      pf_valid <= 1'b1;
      pf_tag <= sram_addr;
      pf_word <= sram_dq_i;
    end else if (start && we && pf_match) begin
      if (address[0] == LANE_HI) pf_word[15:8] <= o_data;
      else pf_word[7:0] <= o_data;
    end
`else
  assign hit = 1'b0;
  assign hit_byte = '0;
`endif
  assign start = state == ST_IDLE && req && !hit;
  assign done = state == ST_STROBE && tc;
  sram_wait_counter u_wait (
    .clock(clock),
    .reset(reset),
    .load(state == ST_SETUP),
    .en(state == ST_STROBE),
    .value(WS),
    .tc(tc)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= ST_IDLE;
      we_q <= 1'b0;
      lane_q <= LANE_LO;
      ready <= 1'b0;
      i_data <= '0;
      sram_addr <= '0;
      sram_dq_o <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end else begin
      ready <= done || hit;
      if (hit) i_data <= hit_byte;
      else if (done && !we_q) i_data <= lane_byte(sram_dq_i, lane_q);
      case (state)
        ST_IDLE:
          if (start) begin
            state <= ST_SETUP;
            we_q <= we;
            lane_q <= address[0];
            sram_addr <= address[19:1];
            sram_ce_n <= 1'b0;
            sram_ub_n <= ~address[0];
            sram_lb_n <= address[0];
            sram_dq_oe <= we;
            sram_oe_n <= we;
            if (we) sram_dq_o <= {o_data, o_data};
          end
        ST_SETUP: begin
          state <= ST_STROBE;
          sram_we_n <= ~we_q;
        end
        ST_STROBE:
          if (tc) begin
            state <= ST_HOLD;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
          end
        default: begin
          state <= ST_IDLE;
          sram_ce_n <= 1'b1;
          sram_ub_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
endmodule
